// File: rtl/store_unit.sv
// store_unit: memory-stage store path; formats one masked word write and runs it over a req/ack bus,
// stalling the pipeline until it completes, is rejected as misaligned, or times out.
module store_unit #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_n_in,
   input  logic        store_valid_in,
   input  logic [1:0]  funct3_in,
   input  logic        flush_in,
   input  logic [31:0] iadder_in,
   input  logic [31:0] rs2_in,
   input  logic        dm_ack_in,
   output logic        dm_wr_req_out,
   output logic [31:0] dm_addr_out,
   output logic [31:0] dm_data_out,
   output logic [3:0]  dm_wr_mask_out,
   output logic        stall_out,
   output logic        store_done_out,
   output logic        misaligned_out,
   output logic        bus_err_out,
   output logic [31:0] err_addr_out
);
   typedef enum logic {IDLE, REQ} state_t;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_q, req_d, done_q, done_d, mis_q, mis_d, berr_q, berr_d;
   logic [31:0]      addr_q, addr_d, data_q, data_d, err_addr_q, err_addr_d;
   logic [3:0]       mask_q, mask_d;
   logic             accept, legal, expire, stall;
   logic [31:0]      fmt_data;
   logic [3:0]       fmt_mask;
   always_comb begin
      accept     = store_valid_in & ~flush_in;
      legal      = (funct3_in == 2'b00) | ((funct3_in == 2'b01) & ~iadder_in[0]) |
                   ((funct3_in == 2'b10) & (iadder_in[1:0] == 2'b00));
      expire     = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      fmt_data   = funct3_in[1] ? rs2_in : funct3_in[0] ? {2{rs2_in[15:0]}} : {4{rs2_in[7:0]}};
      fmt_mask   = funct3_in[1] ? 4'hf : funct3_in[0] ? (iadder_in[1] ? 4'hc : 4'h3) :
                   (4'b0001 << iadder_in[1:0]);
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      addr_d     = addr_q;
      data_d     = data_q;
      mask_d     = mask_q;
      err_addr_d = err_addr_q;
      done_d     = 1'b0;
      mis_d      = 1'b0;
      berr_d     = 1'b0;
      stall      = 1'b0;
      if (state_q == IDLE) begin
         if (accept && legal) begin
            state_d = REQ;
            req_d   = 1'b1;
            cnt_d   = '0;
            addr_d  = {iadder_in[31:2], 2'b00};
            data_d  = fmt_data;
            mask_d  = fmt_mask;
            stall   = 1'b1;
         end else if (accept) begin
            mis_d      = 1'b1;
            err_addr_d = iadder_in;
         end
      end else if (dm_ack_in) begin
         // ack beats a simultaneous timeout expiry
         state_d = IDLE;
         req_d   = 1'b0;
         done_d  = 1'b1;
      end else if (expire) begin
         state_d    = IDLE;
         req_d      = 1'b0;
         berr_d     = 1'b1;
         err_addr_d = addr_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         stall = 1'b1;
      end
   end
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         mask_q     <= '0;
         err_addr_q <= '0;
         done_q     <= 1'b0;
         mis_q      <= 1'b0;
         berr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         mask_q     <= mask_d;
         err_addr_q <= err_addr_d;
         done_q     <= done_d;
         mis_q      <= mis_d;
         berr_q     <= berr_d;
      end
   end
   assign dm_wr_req_out  = req_q;
   assign dm_addr_out    = addr_q;
   assign dm_data_out    = data_q;
   assign dm_wr_mask_out = mask_q;
   // stall is combinational, so it is forced low while reset is held
   assign stall_out      = stall & ms_riscv32_mp_rst_n_in;
   assign store_done_out = done_q;
   assign misaligned_out = mis_q;
   assign bus_err_out    = berr_q;
   assign err_addr_out   = err_addr_q;
endmodule
